// File: rtl/barrett_for_3923_if.sv
`default_nettype none
// ============================================================================
// Module      : barrett_for_3923_if
// Description : Operand/result bundle for the mod-3923 Barrett reducer.
//               master : operand source (drives in_valid/din_a, sees results)
//               slave  : reducer (sees operands, drives out_valid/dout_r)
//   in_valid  1      din_a holds a valid operand this cycle
//   din_a     IN_W   unsigned operand
//   out_valid 1      dout_r holds a new result this cycle
//   dout_r    OUT_W  residue din_a mod 3923
// Revision    : 1.0 - initial release
// ============================================================================
interface barrett_for_3923_if #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 12
);
    logic             in_valid;
    logic [IN_W-1:0]  din_a;
    logic             out_valid;
    logic [OUT_W-1:0] dout_r;

    modport master (
        output in_valid,
        output din_a,
        input  out_valid,
        input  dout_r
    );

    modport slave (
        input  in_valid,
        input  din_a,
        output out_valid,
        output dout_r
    );
endinterface
`default_nettype wire

// File: rtl/barrett_for_3923.sv
`default_nettype none
// ============================================================================
// Module      : barrett_for_3923
// Description : Three-stage pipelined Barrett reducer computing x mod 3923 for
//               any 23-bit unsigned x. One operand per clock, no back-pressure,
//               latency 3 cycles from sampling edge to out_valid.
// Ports       : clk    - system clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - slave modport: in_valid/din_a in, out_valid/dout_r out
// Revision    : 1.0 - initial release
// ============================================================================
module barrett_for_3923 #(
    parameter int Q     = 3923,   // prime modulus; only value supported
    parameter int IN_W  = 23,
    parameter int OUT_W = 12,
    parameter int K     = 24,     // Barrett shift, 2*OUT_W
    parameter int M     = 4276    // floor(2^K / Q)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    barrett_for_3923_if.slave   bus
);

    localparam int M_W = 13;              // width of M
    localparam int P_W = IN_W + M_W;      // 36-bit product x*M
    localparam int R_W = OUT_W + 2;       // r < 3Q = 11769 fits in 14 bits

    localparam logic [P_W-1:0]  C_M_P   = P_W'(M);
    localparam logic [IN_W-1:0] C_Q_IN  = IN_W'(Q);
    localparam logic [R_W-1:0]  C_Q_R   = R_W'(Q);
    localparam logic [R_W-1:0]  C_2Q_R  = R_W'(2 * Q);

    // ------------------------------------------------------------------
    // Valid pipeline: one bit per stage, independent of data.
    // ------------------------------------------------------------------
    logic [1:0]       r_v;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_dout;

    // ------------------------------------------------------------------
    // Stage 1: register x and p = x*M.
    // ------------------------------------------------------------------
    logic [P_W-1:0]  w_prod;
    logic [IN_W-1:0] r_x1;
    logic [P_W-1:0]  r_p1;

    assign w_prod = P_W'(bus.din_a) * C_M_P;

    // ------------------------------------------------------------------
    // Stage 2: t = p >> K (estimated quotient), r = x - t*Q.
    // t underestimates floor(x/Q) by at most 2, so x - t*Q is never
    // negative and stays below 3Q; the low R_W bits are therefore exact.
    // ------------------------------------------------------------------
    logic [P_W-K-1:0] w_t;
    logic [IN_W-1:0]  w_tq;
    logic [IN_W-1:0]  w_diff;
    logic [R_W-1:0]   r_r2;

    assign w_t    = r_p1[P_W-1:K];
    assign w_tq   = IN_W'(w_t) * C_Q_IN;
    assign w_diff = r_x1 - w_tq;

    // ------------------------------------------------------------------
    // Stage 3: final correction, at most two subtractions of Q.
    // ------------------------------------------------------------------
    logic [R_W-1:0] w_red;

    always_comb begin
        w_red = r_r2;
        if (r_r2 >= C_2Q_R) begin
            w_red = r_r2 - C_2Q_R;
        end else if (r_r2 >= C_Q_R) begin
            w_red = r_r2 - C_Q_R;
        end
    end

    // Bits that are provably zero or discarded by the shift.
    logic w_unused;
    assign w_unused = ^{r_p1[K-1:0], w_diff[IN_W-1:R_W], w_red[R_W-1:OUT_W]};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v         <= '0;
            r_x1        <= '0;
            r_p1        <= '0;
            r_r2        <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_v[0]      <= bus.in_valid;
            r_v[1]      <= r_v[0];
            r_out_valid <= r_v[1];

            // Data stages run freely; only the valid bits qualify them.
            r_x1 <= bus.din_a;
            r_p1 <= w_prod;
            r_r2 <= w_diff[R_W-1:0];

            // Result register holds its last value across invalid cycles.
            if (r_v[1]) begin
                r_dout <= w_red[OUT_W-1:0];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout_r    = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_barrett_for_3923.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrett_for_3923
// Description : Self-checking bench for barrett_for_3923. Expected residues
//               are queued when operands are driven and compared when the
//               reducer raises out_valid; a 3-deep valid shadow tracks the
//               required output-valid timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrett_for_3923;

    logic clk;
    logic rst_n;

    barrett_for_3923_if #(.IN_W(23), .OUT_W(12)) bus ();

    barrett_for_3923 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] sb[$];
    logic [2:0]  exp_pipe = 3'b000;
    logic [11:0] last_dout = 12'd0;

    task automatic check_outputs();
        logic [11:0] e;
        checks++;
        assert (bus.out_valid === exp_pipe[2]) else begin
            failures++;
            $error("FAIL out_valid observed=%0b expected=%0b", bus.out_valid, exp_pipe[2]);
        end
        if (exp_pipe[2]) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL scoreboard_empty observed=%0d expected=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (bus.dout_r === e) else begin
                    failures++;
                    $error("FAIL dout_r observed=%0d expected=%0d", bus.dout_r, e);
                end
                last_dout = e;
            end
        end else begin
            checks++;
            assert (bus.dout_r === last_dout) else begin
                failures++;
                $error("FAIL dout_hold observed=%0d expected=%0d", bus.dout_r, last_dout);
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then drive the next inputs.
    task automatic cycle(input bit rst, input bit v, input logic [22:0] x,
                         input logic [11:0] e, input bit chk);
        @(negedge clk);
        if (chk) check_outputs();
        rst_n        = !rst;
        bus.in_valid = v;
        bus.din_a    = x;
        if (rst) begin
            exp_pipe  = 3'b000;
            sb.delete();
            last_dout = 12'd0;
        end else begin
            exp_pipe = {exp_pipe[1:0], v};
            if (v) sb.push_back(e);
        end
    endtask

    task automatic send(input logic [22:0] x);
        cycle(1'b0, 1'b1, x, 12'(x % 23'd3923), 1'b1);
    endtask

    task automatic send_known(input logic [22:0] x, input logic [11:0] e);
        cycle(1'b0, 1'b1, x, e, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 23'd0, 12'd0, 1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.din_a    = 23'd0;

        // Reset for two cycles; first edge brings the pipeline out of X.
        cycle(1'b1, 1'b0, 23'd0, 12'd0, 1'b0);
        cycle(1'b1, 1'b0, 23'd0, 12'd0, 1'b1);
        idle(5);

        // Full residue sweep, back-to-back.
        for (int i = 0; i < 3923; i++) send(23'(i));
        idle(4);

        // Boundaries with hand-derived residues.
        send_known(23'd3923,    12'd0);
        send_known(23'd7846,    12'd0);
        send_known(23'd3923000, 12'd0);
        send_known(23'd3922999, 12'd3922);
        send_known(23'd8388607, 12'd1233);
        send_known(23'd8387374, 12'd0);
        send_known(23'd3922,    12'd3922);
        idle(2);
        send_known(23'd7845,    12'd3922);
        idle(4);

        // Random operands with random gaps.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            send(23'($urandom));
        end
        idle(4);

        // Reset mid-stream after the second operand.
        send(23'd1234567);
        send(23'd7654321);
        cycle(1'b1, 1'b1, 23'd5555555, 12'd0, 1'b1);
        send(23'd4000000);
        send(23'd8000001);
        send(23'd3923);
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
